// File: rtl/dm_arbiter_if.sv
// Two-requester data-memory arbitration bus: requester side, grant/completion
// side, and the single-port memory port driven by the arbiter.
interface dm_arbiter_if;
  logic        m0_req,  m1_req;
  logic        m0_we,   m1_we;
  logic        m0_lock, m1_lock;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wd,   m1_wd;
  logic        m0_gnt,  m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic        m0_err,  m1_err;
  logic [31:0] rdata;
  logic        dm_WE;
  logic [31:0] dm_addr;
  logic [31:0] dm_WD;
  logic [31:0] dm_D;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
           m0_addr, m1_addr, m0_wd, m1_wd, dm_D,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err,
           rdata, dm_WE, dm_addr, dm_WD
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
           m0_addr, m1_addr, m0_wd, m1_wd, dm_D,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err,
           rdata, dm_WE, dm_addr, dm_WD
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-master arbiter in front of a 3072-word single-port data memory, with lock.
// Define DM_ARB_RR_EN for round-robin tie-break; default is fixed m0 priority.
module dm_arbiter (
  input  logic         Clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);
  localparam logic [11:0] DM_WORDS = 12'd3072;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state, state_nxt;
  logic [1:0]        req, we, lock, inr, gnt, rvalid, err;
  logic [1:0][31:0]  addr, wd;
  logic              sel, prio1, rd_hit;
  logic [31:0]       rdata;

  assign req  = {bus.m1_req,  bus.m0_req};
  assign we   = {bus.m1_we,   bus.m0_we};
  assign lock = {bus.m1_lock, bus.m0_lock};
  assign addr = {bus.m1_addr, bus.m0_addr};
  assign wd   = {bus.m1_wd,   bus.m0_wd};

  for (genvar i = 0; i < 2; i++) begin : g_range
    assign inr[i] = addr[i][13:2] < DM_WORDS;
  end

`ifdef DM_ARB_RR_EN
  // Set when m0 was the last IDLE-state grant, so m1 wins the next tie.
  logic rr_ptr;
  always_ff @(posedge Clk) begin
    if (reset)                     rr_ptr <= 1'b0;
    else if (state == IDLE && |gnt) rr_ptr <= gnt[0];
  end
  assign prio1 = rr_ptr;
`else
  assign prio1 = 1'b0;
`endif

  always_comb begin
    gnt       = '0;
    state_nxt = state;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (req[0] && (!req[1] || !prio1)) gnt = 2'b01;
          else if (req[1])                   gnt = 2'b10;
          if (gnt[0] && lock[0])      state_nxt = OWN0;
          else if (gnt[1] && lock[1]) state_nxt = OWN1;
        end
        OWN0: begin
          gnt[0] = req[0];
          if (!lock[0]) state_nxt = IDLE;
        end
        OWN1: begin
          gnt[1] = req[1];
          if (!lock[1]) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign sel         = gnt[1];
  assign bus.dm_addr = (|gnt) ? addr[sel] : 32'h0;
  assign bus.dm_WD   = (|gnt) ? wd[sel]   : 32'h0;
  assign bus.dm_WE   = (|gnt) & we[sel] & inr[sel];
  assign rd_hit      = (|gnt) & ~we[sel] & inr[sel];

  always_ff @(posedge Clk) begin
    if (reset) begin
      state  <= IDLE;
      rvalid <= '0;
      err    <= '0;
      rdata  <= '0;
    end else begin
      state  <= state_nxt;
      rvalid <= gnt;
      err    <= gnt & ~inr;
      rdata  <= rd_hit ? bus.dm_D : 32'h0;
    end
  end

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = rvalid[0];
  assign bus.m1_rvalid = rvalid[1];
  assign bus.m0_err    = err[0];
  assign bus.m1_err    = err[1];
  assign bus.rdata     = rdata;
endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios then randomized traffic
// against a transaction-level ownership/memory model.
module tb_dm_arbiter;
  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  dm_arbiter_if bus();
  dm_arbiter dut (.Clk(Clk), .reset(reset), .bus(bus));

  // Environment memory: unwritten words read back a deterministic pattern.
  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  logic [31:0] mem [0:3071];
  bit          wr_seen [0:3071];
  logic [11:0] didx;
  assign didx = bus.dm_addr[13:2];

  always_comb begin
    if (didx < 12'd3072 && wr_seen[didx]) bus.dm_D = mem[didx];
    else                                  bus.dm_D = init_word(int'(didx));
  end

  always @(posedge Clk) begin
    if (bus.dm_WE && didx < 12'd3072) begin
      mem[didx]     <= bus.dm_WD;
      wr_seen[didx] <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] refm [0:3071];
  int owner;     // -1 = nobody holds a lock, else locked master
  int last_g;    // master of the most recent unlocked-state grant
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r0, input bit w0, input bit l0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit r1, input bit w1, input bit l1, input logic [31:0] a1, input logic [31:0] d1);
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_lock = l0; bus.m0_addr = a0; bus.m0_wd = d0;
    bus.m1_req = r1; bus.m1_we = w1; bus.m1_lock = l1; bus.m1_addr = a1; bus.m1_wd = d1;
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return a[13:2] < 12'd3072;
  endfunction

  // One clock: inputs were driven after the previous negedge.
  task automatic cycle();
    bit g0, g1, w, l, rr;
    logic [31:0] a, d, exp_rd;
    int m;
    g0 = 0; g1 = 0;
    rr = 0;
`ifdef DM_ARB_RR_EN
    rr = 1;
`endif
    #1;
    if (!reset) begin
      if (owner == 0)      g0 = bus.m0_req;
      else if (owner == 1) g1 = bus.m1_req;
      else if (bus.m0_req && bus.m1_req) begin
        if (rr && last_g == 0) g1 = 1; else g0 = 1;
      end else begin
        g0 = bus.m0_req; g1 = bus.m1_req;
      end
    end
    m = g1 ? 1 : 0;
    a = m ? bus.m1_addr : bus.m0_addr;
    d = m ? bus.m1_wd   : bus.m0_wd;
    w = m ? bus.m1_we   : bus.m0_we;
    l = m ? bus.m1_lock : bus.m0_lock;
    chk("m0_gnt", bus.m0_gnt, g0);
    chk("m1_gnt", bus.m1_gnt, g1);
    chk("dm_WE",  bus.dm_WE,  (g0 | g1) & w & in_range(a));
    chk("dm_addr", bus.dm_addr, (g0 | g1) ? a : 32'h0);
    chk("dm_WD",   bus.dm_WD,   (g0 | g1) ? d : 32'h0);
    exp_rd = 32'h0;
    if ((g0 | g1) && !w && in_range(a)) exp_rd = refm[a[13:2]];
    @(posedge Clk);
    if (reset) begin
      owner = -1; last_g = 1; exp_rd = 32'h0;
    end else begin
      if ((g0 | g1) && w && in_range(a)) refm[a[13:2]] = d;
      if (owner == -1) begin
        if (g0 | g1) last_g = m;
        if ((g0 | g1) && l) owner = m;
      end else if (owner == 0 && !bus.m0_lock) owner = -1;
      else if (owner == 1 && !bus.m1_lock) owner = -1;
    end
    @(negedge Clk);
    chk("m0_rvalid", bus.m0_rvalid, g0);
    chk("m1_rvalid", bus.m1_rvalid, g1);
    chk("m0_err", bus.m0_err, g0 & !in_range(a));
    chk("m1_err", bus.m1_err, g1 & !in_range(a));
    chk("rdata",  bus.rdata,  exp_rd);
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] r;
    logic [11:0] idx;
    int k;
    r = $urandom;
    k = $urandom_range(0, 3);
    if (k < 2)       idx = 12'($urandom_range(0, 7));
    else if (k == 2) idx = 12'($urandom_range(3068, 3075));
    else             idx = 12'($urandom_range(0, 4095));
    return {r[31:14], idx, r[1:0]};
  endfunction

  initial begin
    for (int i = 0; i < 3072; i++) refm[i] = init_word(i);
    owner = -1; last_g = 1;
    reset = 1'b1;
    drive(0,0,0,0,0, 0,0,0,0,0);
    @(negedge Clk);
    // Reset state, including a request held during reset
    cycle();
    drive(1,1,0,32'h10,32'hDEAD_BEEF, 1,0,0,32'h20,0);
    cycle();
    chk("reset_rvalid", bus.m0_rvalid, 1'b0);
    reset = 1'b0;

    // Write then read back through m0
    drive(1,1,0,32'h10,32'h1234_5678, 0,0,0,0,0);
    cycle();
    drive(1,0,0,32'h10,0, 0,0,0,0,0);
    cycle();
    chk("wr_rd_data", bus.rdata, 32'h1234_5678);
    chk("wr_rd_err",  bus.m0_err, 1'b0);

    // Simultaneous unlocked requests
    for (int i = 0; i < 6; i++) begin
      drive(1,0,0,32'h10,0, 1,0,0,32'h14,0);
      cycle();
    end

    // m1 locked for 3 grants, drops lock on 4th, m0 waits then wins
    drive(0,0,0,0,0, 1,0,1,32'h18,0);
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive(1,0,0,32'h10,0, 1,0,1,32'h18,0);
      cycle();
      chk("lock_m0_wait", bus.m0_gnt, 1'b0);
    end
    drive(1,0,0,32'h10,0, 1,0,0,32'h18,0);
    cycle();
    drive(1,0,0,32'h10,0, 0,0,0,0,0);
    cycle();
    chk("lock_m0_after", bus.m0_rvalid, 1'b1);

    // Out-of-range write
    drive(1,1,0,32'h3000,32'hCAFE_F00D, 0,0,0,0,0);
    cycle();
    chk("oor_err",   bus.m0_err, 1'b1);
    chk("oor_rdata", bus.rdata,  32'h0);

    // Reset while m0 holds a lock
    drive(1,0,1,32'h8,0, 0,0,0,0,0);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    chk("rst_own_rdata", bus.rdata, 32'h0);
    reset = 1'b0;
    drive(0,0,0,0,0, 1,0,0,32'h4,0);
    cycle();

    // m1 reads what m0 wrote the cycle before
    drive(1,1,0,32'h4,32'hA5A5_0F0F, 0,0,0,0,0);
    cycle();
    drive(0,0,0,0,0, 1,0,0,32'h4,0);
    cycle();
    chk("raw_rdata", bus.rdata, 32'hA5A5_0F0F);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0,3) != 0, 1'($urandom), $urandom_range(0,3) == 0, raddr(), $urandom,
            $urandom_range(0,3) != 0, 1'($urandom), $urandom_range(0,3) == 0, raddr(), $urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have ports: Clk  in  1  clock; all state updates on posedge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: m0_req/m1_req  in  1 each  requester access request; held high until granted.
REQ-004 SHALL have ports: m0_we/m1_we  in  1 each  1=write, 0=read.
REQ-005 SHALL have ports: m0_lock/m1_lock  in  1 each  keep ownership after the current grant.
REQ-006 SHALL have ports: m0_addr/m1_addr  in  32 each  byte address; word index = addr[13:2].
REQ-007 SHALL have ports: m0_wd/m1_wd  in  32 each  write data.
REQ-008 SHALL have ports: m0_gnt/m1_gnt  out  1 each  combinational grant; access is performed at this cycle's posedge.
REQ-009 SHALL have ports: m0_rvalid/m1_rvalid  out  1 each  registered completion pulse, one cycle after grant.
REQ-010 SHALL have ports: m0_err/m1_err  out  1 each  registered, coincident with rvalid; 1 = word index >= 3072.
REQ-011 SHALL have ports: rdata  out  32  registered read data, valid while either rvalid is high.
REQ-012 SHALL have ports: dm_WE  out  1, dm_addr  out  32, dm_WD  out  32  drive the single-port data memory (3072 words).
REQ-013 SHALL have ports: dm_D  in  32  asynchronous memory read data.

Function
REQ-014 SHALL run FSM states IDLE, OWN0, OWN1; only one grant per cycle; m0_gnt & m1_gnt never both 1.
REQ-015 SHALL, in IDLE, grant per arbitration policy (REQ-029) among asserted reqs; no req -> no grant, dm_WE=0.
REQ-016 SHALL, in OWNx, grant only mx; the other requester waits regardless of req.
REQ-017 SHALL transition IDLE->OWNx when mx granted with mx_lock=1; else stay IDLE.
REQ-018 SHALL transition OWNx->IDLE when mx_lock=0, whether or not mx_req=1 (final access still granted if req=1).
REQ-019 SHALL drive dm_addr/dm_WD from the granted port; dm_WE = gnt & we & in-range; when nothing granted, dm_addr=0, dm_WD=0.
REQ-020 SHALL treat word index addr[13:2] >= 3072 as out-of-range: dm_WE forced 0, rdata=0, err=1 with rvalid.
REQ-021 SHALL capture dm_D into rdata at the grant edge for in-range reads; writes and out-of-range set rdata=0.
REQ-022 SHALL give a 1-cycle latency: gnt in cycle N -> rvalid (and err) high exactly in cycle N+1 for one cycle.
REQ-023 SHALL support back-to-back grants: a new grant in cycle N+1 overlapping the rvalid of cycle N's access.
REQ-024 SHALL ignore addr[31:14] and addr[1:0].

Reset
REQ-025 SHALL, while reset=1 at posedge, set FSM=IDLE, rvalid=0, err=0, rdata=0, RR pointer=m0-priority.
REQ-026 SHALL force gnt=0 and dm_WE=0 during any cycle with reset=1; a locked transfer is abandoned with no rvalid.
REQ-027 SHALL not clear memory contents; memory clearing is not the arbiter's job.
REQ-028 SHALL grant normally in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL implement macro DM_ARB_RR_EN.
- Defined: round-robin; pointer toggles to the other master after each IDLE-state grant; on simultaneous reqs, the master not last granted wins.
- Undefined: fixed priority; m0 always wins simultaneous reqs in IDLE; pointer logic absent.

Verification
REQ-030 SHALL pass: m0 writes 0x12345678 to addr 0x10, m0 reads 0x10 -> rvalid next cycle, rdata=0x12345678, err=0.
REQ-031 SHALL pass: both req every cycle, no lock, DM_ARB_RR_EN defined -> grants alternate m0,m1,m0,m1; undefined -> m0 every cycle.
REQ-032 SHALL pass: m1 lock=1 for 3 grants while m0 req held -> m0_gnt=0 until cycle after m1_lock drops, then m0 granted.
REQ-033 SHALL pass: m0 write addr 0x3000 (index 3072) -> dm_WE=0, next cycle m0_rvalid=1, m0_err=1, rdata=0.
REQ-034 SHALL pass: reset asserted during OWN0 -> same cycle gnt=0; next cycle FSM=IDLE, rvalid=0, rdata=0.
REQ-035 SHALL pass: m1 read of 0x4 while m0 write same address in prior cycle -> m1 rdata equals m0 written value.
